// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_generator_if.sv
// Control/status bundle of sequence_generator; signal suffixes are relative to the generator.
interface sequence_generator_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned REPEAT_W = 4
);

  logic                start_i;
  logic                abort_i;
  logic [WIDTH-1:0]    pattern_in_i;
  logic [REPEAT_W-1:0] repeat_count_i;
  logic                sequence_o;
  logic                seq_valid_o;
  logic                busy_o;
  logic                done_o;

  modport master (
    output start_i, abort_i, pattern_in_i, repeat_count_i,
    input  sequence_o, seq_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, pattern_in_i, repeat_count_i,
    output sequence_o, seq_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/seqgen_shifter.sv
// Pattern register, shift register of the bits still to send, and down-counting bit counter.
// Optional parity output under SEQGEN_PARITY_EN.
module seqgen_shifter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = seqgen_pkg::DEFAULT_PATTERN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             reload_i,
  input  logic             shift_i,
  output logic             first_bit_o,
  output logic             next_bit_o,
  output logic             last_bit_o
`ifdef SEQGEN_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  localparam int unsigned       CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(WIDTH - 1);

  // shreg_q holds only the bits after the one currently on the line
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-2:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_q <= INIT;
      shreg_q   <= INIT[WIDTH-2:0];
      cnt_q     <= '0;
    end else if (load_i) begin
      pattern_q <= data_i;
      shreg_q   <= data_i[WIDTH-2:0];
      cnt_q     <= CNT_TOP;
    end else if (reload_i) begin
      shreg_q   <= pattern_q[WIDTH-2:0];
      cnt_q     <= CNT_TOP;
    end else if (shift_i) begin
      shreg_q   <= shreg_q << 1;
      cnt_q     <= cnt_q - 1'b1;
    end
  end

  assign first_bit_o = pattern_q[WIDTH-1];
  assign next_bit_o  = shreg_q[WIDTH-2];
  assign last_bit_o  = (cnt_q == '0);
`ifdef SEQGEN_PARITY_EN
  assign parity_o    = ^pattern_q;
`endif

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first repeat_count times, then pulses done.
// Optional per-frame even parity bit when SEQGEN_PARITY_EN is defined.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      REPEAT_W        = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = seqgen_pkg::DEFAULT_PATTERN
) (
  input logic                 clock,
  input logic                 reset,
  sequence_generator_if.slave bus
);

  state_t              state_q;
  logic [REPEAT_W-1:0] rep_q;
  logic                seq_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  logic load;
  logic reload;
  logic shift;
  logic first_bit;
  logic next_bit;
  logic last_bit;
  logic frame_end;

`ifdef SEQGEN_PARITY_EN
  logic par_q;
  logic parity;
  assign frame_end = par_q;
`else
  assign frame_end = last_bit;
`endif

  seqgen_shifter #(
    .WIDTH (WIDTH),
    .INIT  (DEFAULT_PATTERN)
  ) u_shifter (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .data_i      (bus.pattern_in_i),
    .reload_i    (reload),
    .shift_i     (shift),
    .first_bit_o (first_bit),
    .next_bit_o  (next_bit),
    .last_bit_o  (last_bit)
`ifdef SEQGEN_PARITY_EN
    ,
    .parity_o    (parity)
`endif
  );

  always_comb begin
    load   = 1'b0;
    reload = 1'b0;
    shift  = 1'b0;
    if (!bus.abort_i) begin
      case (state_q)
        IDLE: load = bus.start_i && (bus.repeat_count_i != '0);
        SEND: begin
          if (!last_bit) begin
            shift = 1'b1;
          end else if (frame_end && (rep_q > REPEAT_W'(1))) begin
            reload = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // abort outranks every state, including a start seen in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rep_q   <= '0;
      seq_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (bus.abort_i) begin
      state_q <= IDLE;
      rep_q   <= '0;
      seq_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.repeat_count_i != '0) begin
              state_q <= SEND;
              rep_q   <= bus.repeat_count_i;
              seq_q   <= bus.pattern_in_i[WIDTH-1];
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (shift) begin
            seq_q <= next_bit;
          end else if (reload) begin
            seq_q <= first_bit;
            rep_q <= rep_q - 1'b1;
`ifdef SEQGEN_PARITY_EN
            par_q <= 1'b0;
          end else if (!par_q) begin
            seq_q <= parity;
            par_q <= 1'b1;
`endif
          end else begin
            state_q <= DONE;
            rep_q   <= '0;
            seq_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef SEQGEN_PARITY_EN
            par_q   <= 1'b0;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          seq_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sequence_o  = seq_q;
  assign bus.seq_valid_o = valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: the driver queues expected bits/done pulses with
// their cycle numbers, a negedge monitor pops and compares whatever the generator presents.
module tb_sequence_generator;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned REPEAT_W = 4;
`ifdef SEQGEN_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  typedef struct {
    logic        b;
    int unsigned cyc;
  } bit_t;

  typedef struct {
    int unsigned len;
    int unsigned cyc;
  } done_t;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned run_len = 0;
  bit_t        exp_q[$];
  done_t       done_q[$];
  bit_t        mon_b;
  done_t       mon_d;

  sequence_generator_if #(.WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) bus ();

  sequence_generator #(
    .WIDTH           (WIDTH),
    .REPEAT_W        (REPEAT_W),
    .DEFAULT_PATTERN (4'b1011)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: rep frames of the pattern MSB-first (plus parity), bit k at cycle s+k, done at s+total.
  task automatic push_model(input logic [WIDTH-1:0] pat, input int unsigned rep,
                            input int unsigned s, input int unsigned limit, input bit aborted);
    int unsigned k;
    logic        b;
    k = 0;
    for (int unsigned r = 0; r < rep; r++) begin
      for (int unsigned i = 0; i < FRAME; i++) begin
        if (i < WIDTH) b = pat[WIDTH-1-i];
        else           b = ^pat;
        if (k < limit) exp_q.push_back('{b, s + k});
        k++;
      end
    end
    if (!aborted) done_q.push_back('{k, s + k});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // abort_at = 0: run to completion; otherwise abort sampled abort_at edges after the start edge.
  task automatic txn(input logic [WIDTH-1:0] pat, input int unsigned rep, input int unsigned abort_at);
    int unsigned n, s, span;
    n = rep * FRAME;
    bus.start_i        = 1'b1;
    bus.abort_i        = 1'b0;
    bus.pattern_in_i   = pat;
    bus.repeat_count_i = REPEAT_W'(rep);
    @(posedge clock); #1;
    s = cyc;
    push_model(pat, rep, s, (abort_at != 0) ? abort_at : n, abort_at != 0);
    span = (abort_at != 0) ? abort_at : n + 1;
    for (int unsigned i = 1; i <= span; i++) begin
      bus.start_i        = 1'($urandom_range(0, 1));
      bus.pattern_in_i   = WIDTH'($urandom);
      bus.repeat_count_i = REPEAT_W'($urandom);
      bus.abort_i        = (abort_at != 0) && (i == abort_at);
      @(posedge clock); #1;
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.seq_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: seq_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          mon_b = exp_q.pop_front();
          chk("bit_value", bus.sequence_o, mon_b.b);
          chk("bit_cycle", cyc, mon_b.cyc);
          chk("busy_in_send", bus.busy_o, 1);
        end
        run_len++;
      end else begin
        if (bus.sequence_o) chk("sequence_idle", bus.sequence_o, 0);
        if (bus.busy_o)     chk("busy_idle", bus.busy_o, 0);
        if (bus.done_o) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
          end else begin
            mon_d = done_q.pop_front();
            chk("done_run_length", run_len, mon_d.len);
            chk("done_cycle", cyc, mon_d.cyc);
          end
        end
        run_len = 0;
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] p;
    int unsigned      r, a, s;

    reset              = 1'b1;
    bus.start_i        = 1'b0;
    bus.abort_i        = 1'b0;
    bus.pattern_in_i   = '0;
    bus.repeat_count_i = '0;
    #1;
    chk("reset_sequence", bus.sequence_o, 0);
    chk("reset_seq_valid", bus.seq_valid_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_done", bus.done_o, 0);
    idle(2);
    reset = 1'b0;
    idle(1);

    txn(4'b1011, 1, 0);
    idle(1);
    txn(4'b1011, 2, 0);
    idle(1);
    txn(4'b0000, 0, 0);
    idle(1);
    txn(4'b1011, 3, 5);
    idle(2);
    txn(4'b1011, 1, 0);
    idle(1);

    // start and abort together in IDLE: nothing may be accepted
    bus.start_i        = 1'b1;
    bus.abort_i        = 1'b1;
    bus.pattern_in_i   = 4'b1111;
    bus.repeat_count_i = 4'd2;
    @(posedge clock); #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    idle(3);

    // asynchronous reset mid-transmission
    bus.start_i        = 1'b1;
    bus.pattern_in_i   = 4'b1011;
    bus.repeat_count_i = 4'd3;
    @(posedge clock); #1;
    bus.start_i = 1'b0;
    s = cyc;
    push_model(4'b1011, 3, s, 3, 1'b1);
    idle(2);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_sequence", bus.sequence_o, 0);
    chk("async_reset_seq_valid", bus.seq_valid_o, 0);
    chk("async_reset_busy", bus.busy_o, 0);
    chk("async_reset_done", bus.done_o, 0);
    chk("async_reset_bits_seen", exp_q.size(), 0);
    exp_q.delete();
    done_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);
    txn(4'b0110, 2, 0);
    idle(1);

    for (int t = 0; t < 40; t++) begin
      p = WIDTH'($urandom);
      r = (t % 13 == 7) ? 15 : $urandom_range(0, 4);
      a = 0;
      if (r != 0 && $urandom_range(0, 5) == 0) a = $urandom_range(1, r * FRAME);
      txn(p, r, a);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("leftover_bits", exp_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter; the sending end of the serial-bit link whose receiving end is the team's 1011 sequence detector.
- Latches a WIDTH-bit pattern and a repeat count on a start pulse.
- Emits the pattern MSB-first, one bit per clock, back-to-back for the requested number of repetitions, then pulses done.
- Drives the detector's serial input in loopback benches and in on-chip self-test.

Parameters:
- WIDTH, 4, pattern length in bits (>=2).
- REPEAT_W, 4, width of repeat_count.
- DEFAULT_PATTERN, 4'b1011, value loaded into the pattern register at reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request; sampled on a rising edge, honoured only in IDLE.
- abort  input  1  terminates transmission at the next edge.
- pattern_in  input  WIDTH  pattern to send; latched when start is accepted.
- repeat_count  input  REPEAT_W  number of pattern emissions; latched with pattern_in.
- sequence  output  1  serial data bit (registered).
- seq_valid  output  1  high while sequence carries a pattern bit (registered).
- busy  output  1  high in SEND (registered).
- done  output  1  one-cycle pulse after the last bit (registered).

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clock.
- Reset values:
  - sequence=0, seq_valid=0, busy=0, done=0.
  - state=IDLE; pattern register=DEFAULT_PATTERN; bit counter=0; repeat counter=0.
- States: IDLE, SEND, DONE (2-bit encoding).
- IDLE:
  - Outputs 0.
  - start=1 at edge N with repeat_count!=0: latch pattern_in and repeat_count, enter SEND.
  - At that same edge: sequence=pattern_in[WIDTH-1], seq_valid=1, busy=1.
  - Latency: the first bit is valid in the cycle after the start edge.
- IDLE, repeat_count==0:
  - start=1 goes to DONE directly; no bits are emitted; done pulses for one cycle.
- SEND:
  - Each edge advances one bit, MSB to LSB.
  - After bit 0 of a repetition, if repetitions remain: reload from the latched pattern with no gap cycle and decrement the repeat counter.
  - After bit 0 of the final repetition: go to DONE. In DONE, seq_valid=0, sequence=0, busy=0, done=1.
  - Total SEND cycles = WIDTH x repeat_count.
- DONE: lasts exactly one cycle, then IDLE. A start during DONE is ignored.
- start while busy: ignored. The latched pattern and count are unaffected by changes on pattern_in/repeat_count during SEND.
- abort=1 in SEND or DONE:
  - Next edge: IDLE, all outputs 0, no done pulse.
  - abort and start both high in IDLE: abort wins; start is not accepted.
- Reset mid-operation: immediate return to the reset values; the pattern register is reloaded with DEFAULT_PATTERN.
- Arithmetic:
  - Bit counter is ceil(log2(WIDTH)) bits and counts down from WIDTH-1 to 0.
  - Repeat counter is REPEAT_W bits and is never decremented below 0.
  - Maximum repeat_count=2^REPEAT_W-1 with no wrap.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined:
  - After each repetition's bit 0, one extra SEND cycle emits the even parity of the latched pattern, with seq_valid=1.
  - Frame length is WIDTH+1; total SEND cycles = (WIDTH+1) x repeat_count.
  - The parity bit is the XOR of all pattern bits.
- Undefined: no parity cycle; frame length is WIDTH.

Decomposition:
- Package seqgen_pkg:
  - State encoding constants IDLE=2'b00, SEND=2'b01, DONE=2'b10.
  - DEFAULT_PATTERN constant.
- Sub-module seqgen_shifter:
  - Parallel-load shift register plus bit counter.
  - Outputs last_bit and, under SEQGEN_PARITY_EN, the parity bit.
- The top level holds the FSM, repeat counter and output registers.

Test Plan:
- pattern_in=4'b1011, repeat_count=1, start pulse at cycle 0 -> sequence=1,0,1,1 with seq_valid=1 in cycles 1-4; done=1 in cycle 5 only; busy=1 in cycles 1-4.
- pattern 1011, repeat_count=2, looped back to the 1011 detector -> 8 contiguous valid bits 10111011; detector asserts after bit 4 and after bit 8; done in cycle 9.
- repeat_count=0, start -> no seq_valid; done in cycle 1; back in IDLE in cycle 2.
- repeat 3, abort asserted during cycle 5 -> outputs 0 from the following edge; no done; start two cycles later is accepted normally.
- start re-pulsed and pattern_in changed to 4'b0110 mid-SEND -> ignored; output continues 1011.
- SEQGEN_PARITY_EN defined, pattern 1011, repeat 1 -> sequence 1,0,1,1,1 (parity=1) in cycles 1-5; done in cycle 6.
- Async reset asserted mid-SEND -> all outputs 0 immediately, without waiting for a clock edge.
